bank_shift_out: RTL and testbench

//  Downstream consumer of the UART frame parser. Takes each parsed 256-bit frame plus its bank number
//  and stores it in a per-bank register. After any update it streams all banks, as one frame, to an

---
 rtl/bank_shift_out_pkg.sv | 21 ++
 rtl/bank_shift_out_tick.sv | 31 +++
 rtl/bank_shift_out.sv | 140 ++++++++++++++
 tb/tb_bank_shift_out.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_shift_out_pkg.sv
// Shared types and defaults for the bank shift-out block: FSM state encoding and frame sizing.
package bank_shift_out_pkg;

   localparam int DEF_NUM_BANKS      = 4;
   localparam int DEF_DATA_W         = 256;
   localparam int DEF_CLK_DIV        = 4;
   localparam int DEF_REFRESH_CYCLES = 1000000;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT_LO,
      SHIFT_HI,
      LATCH_ST
   } state_t;

   function automatic int frame_bits(input int num_banks, input int data_w);
      return num_banks * data_w;
   endfunction

endpackage

// File: rtl/bank_shift_out_tick.sv
// Half-period tick generator for the serial clock: one tick every CLK_DIV enabled cycles,
// restarted from zero so each shift frame begins with a full-length SCLK phase.
module bank_shift_out_tick
   import bank_shift_out_pkg::*;
#(
   parameter int CLK_DIV = DEF_CLK_DIV
) (
   input  logic CLK,
   input  logic RST,
   input  logic restart,
   input  logic enable,
   output logic tick
);

   localparam int CNT_W = $clog2(CLK_DIV + 1);

   logic [CNT_W-1:0] div_cnt;

   assign tick = enable && (div_cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         div_cnt <= '0;
      end else if (restart || tick) begin
         div_cnt <= '0;
      end else if (enable) begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/bank_shift_out.sv
// Stores parsed frames per bank and streams all banks to a 74HC595-style chain after each update.
// Define BANK_SHIFT_OUT_REFRESH_EN to also re-send the chain every REFRESH_CYCLES clock cycles.
module bank_shift_out
   import bank_shift_out_pkg::*;
#(
   parameter int NUM_BANKS      = DEF_NUM_BANKS,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int CLK_DIV        = DEF_CLK_DIV
`ifdef BANK_SHIFT_OUT_REFRESH_EN
   ,
   parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
`endif
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] DATA_IN,
   input  logic [7:0]        BANK_IN,
   input  logic              DATA_WRITE,
   output logic              SDO,
   output logic              SCLK,
   output logic              LATCH,
   output logic              BUSY,
   output logic              BANK_ERR
);

   localparam int FRAME_BITS = frame_bits(NUM_BANKS, DATA_W);
   localparam int BIT_CNT_W  = $clog2(FRAME_BITS + 1);

   state_t                  state, state_nxt;
   logic [DATA_W-1:0]       bank_q [NUM_BANKS];
   logic [FRAME_BITS-1:0]   snapshot, shift_q;
   logic [BIT_CNT_W-1:0]    bit_cnt;
   logic                    pending, bank_err_q, write_ok, refresh_tick;
   logic                    tick, tick_restart, tick_enable, last_bit;

   assign write_ok     = DATA_WRITE && (int'(BANK_IN) < NUM_BANKS);
   assign last_bit     = (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
   assign tick_restart = (state == LOAD);
   assign tick_enable  = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == LATCH_ST);
   assign BANK_ERR     = bank_err_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int b = 0; b < NUM_BANKS; b++) bank_q[b] <= '0;
      end else if (write_ok) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (int'(BANK_IN) == b) bank_q[b] <= DATA_IN;
         end
      end
   end

   // Bank 0 lands in the low bits so shifting right emits bank 0, bit 0 first.
   always_comb begin
      snapshot = '0;
      for (int b = 0; b < NUM_BANKS; b++) snapshot[b*DATA_W +: DATA_W] = bank_q[b];
   end

   // A write landing in the LOAD cycle wins over the clear, so its data gets its own frame.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pending    <= 1'b0;
         bank_err_q <= 1'b0;
      end else begin
         bank_err_q <= DATA_WRITE && !write_ok;
         if (write_ok || refresh_tick) pending <= 1'b1;
         else if (state == LOAD)       pending <= 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         shift_q <= '0;
         bit_cnt <= '0;
      end else if (state == LOAD) begin
         shift_q <= snapshot;
         bit_cnt <= '0;
      end else if ((state == SHIFT_HI) && tick) begin
         shift_q <= shift_q >> 1;
         bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      SDO       = 1'b0;
      SCLK      = 1'b0;
      LATCH     = 1'b0;
      BUSY      = (state != IDLE);
      case (state)
         IDLE:     if (pending) state_nxt = LOAD;
         LOAD:     state_nxt = SHIFT_LO;
         SHIFT_LO: begin
            SDO = shift_q[0];
            if (tick) state_nxt = SHIFT_HI;
         end
         SHIFT_HI: begin
            SDO  = shift_q[0];
            SCLK = 1'b1;
            if (tick) state_nxt = last_bit ? LATCH_ST : SHIFT_LO;
         end
         LATCH_ST: begin
            LATCH = 1'b1;
            if (tick) state_nxt = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   bank_shift_out_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .CLK     (CLK),
      .RST     (RST),
      .restart (tick_restart),
      .enable  (tick_enable),
      .tick    (tick)
   );

`ifdef BANK_SHIFT_OUT_REFRESH_EN
   localparam int REFRESH_W = $clog2(REFRESH_CYCLES + 1);

   logic [REFRESH_W-1:0] refresh_cnt;

   assign refresh_tick = (refresh_cnt == REFRESH_W'(REFRESH_CYCLES - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)               refresh_cnt <= '0;
      else if (refresh_tick) refresh_cnt <= '0;
      else                   refresh_cnt <= refresh_cnt + 1'b1;
   end
`else
   assign refresh_tick = 1'b0;
`endif

endmodule

// File: tb/tb_bank_shift_out.sv
// Self-checking bench for bank_shift_out (2 banks x 8 bits, CLK_DIV=2); captures whole frames off the
// serial pins and compares them with a bank model. With BANK_SHIFT_OUT_REFRESH_EN it checks the refresh period.
module tb_bank_shift_out;

   localparam int FRAME_LEN = 16;
   localparam int BUSY_LEN  = 1 + FRAME_LEN * 2 * 2 + 2;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] DATA_IN = '0;
   logic [7:0] BANK_IN = '0;
   logic       DATA_WRITE = 1'b0;
   logic       SDO, SCLK, LATCH, BUSY, BANK_ERR;

   typedef struct {
      logic [15:0] data;
      int          nbits;
      int          latch_len;
      int          busy_len;
      int          start_cyc;
   } frame_t;

   typedef struct {
      logic [7:0]  bank;
      logic [7:0]  data;
      logic        exp_err;
      logic        exp_frame;
      logic [15:0] exp_data;
   } vec_t;

   frame_t     frames[$];
   int         next_idx = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] model_bank [2];

   int          cyc = 0;
   logic        mon_active = 1'b0;
   logic        prev_sclk = 1'b0;
   int          mon_nbits = 0;
   frame_t      mon_cur;

   bank_shift_out #(
      .NUM_BANKS      (2),
      .DATA_W         (8),
      .CLK_DIV        (2)
`ifdef BANK_SHIFT_OUT_REFRESH_EN
      ,
      .REFRESH_CYCLES (100)
`endif
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .DATA_IN    (DATA_IN),
      .BANK_IN    (BANK_IN),
      .DATA_WRITE (DATA_WRITE),
      .SDO        (SDO),
      .SCLK       (SCLK),
      .LATCH      (LATCH),
      .BUSY       (BUSY),
      .BANK_ERR   (BANK_ERR)
   );

   always #5 CLK = ~CLK;

   // Pin-level frame capture: one record per BUSY period, SDO taken at each SCLK rise.
   always @(negedge CLK) begin
      cyc = cyc + 1;
      if (RST) begin
         mon_active = 1'b0;
         mon_nbits  = 0;
         prev_sclk  = 1'b0;
      end else begin
         if (BUSY && !mon_active) begin
            mon_active        = 1'b1;
            mon_nbits         = 0;
            mon_cur.data      = '0;
            mon_cur.nbits     = 0;
            mon_cur.latch_len = 0;
            mon_cur.busy_len  = 0;
            mon_cur.start_cyc = cyc;
         end
         if (mon_active) begin
            if (BUSY) mon_cur.busy_len++;
            if (LATCH) mon_cur.latch_len++;
            if (SCLK && !prev_sclk) begin
               if (mon_nbits < FRAME_LEN) mon_cur.data[mon_nbits] = SDO;
               mon_nbits++;
            end
            if (!BUSY) begin
               mon_cur.nbits = mon_nbits;
               frames.push_back(mon_cur);
               mon_active = 1'b0;
            end
         end
         prev_sclk = SCLK;
      end
   end

   function automatic logic [15:0] modelFrame();
      logic [15:0] f;
      for (int j = 0; j < FRAME_LEN; j++) f[j] = model_bank[j / 8][j % 8];
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] bank, input logic [7:0] data);
      @(negedge CLK);
      BANK_IN    = bank;
      DATA_IN    = data;
      DATA_WRITE = 1'b1;
      @(negedge CLK);
      DATA_WRITE = 1'b0;
      if (bank < 8'd2) model_bank[bank[0]] = data;
   endtask

   task automatic waitFrame(output frame_t f, output logic ok);
      ok = 1'b0;
      f  = '{default: 0};
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge CLK);
         if (frames.size() > next_idx) begin
            f  = frames[next_idx];
            next_idx++;
            ok = 1'b1;
         end
      end
   endtask

   task automatic checkFrame(input string name, input logic [15:0] exp_data);
      frame_t f;
      logic   ok;
      waitFrame(f, ok);
      checkOutput({name, "_seen"}, 32'(ok), 32'd1);
      if (ok) begin
         checkOutput({name, "_data"}, 32'(f.data), 32'(exp_data));
         checkOutput({name, "_nbits"}, f.nbits, FRAME_LEN);
         checkOutput({name, "_latch_len"}, f.latch_len, 2);
         checkOutput({name, "_busy_len"}, f.busy_len, BUSY_LEN);
      end
   endtask

   task automatic checkNoFrame(input string name, input int wait_cycles);
      repeat (wait_cycles) @(negedge CLK);
      checkOutput({name, "_no_frame"}, 32'(frames.size() - next_idx), 32'd0);
      checkOutput({name, "_idle"}, 32'(BUSY), 32'd0);
   endtask

   task automatic checkWrite(input string name, input logic [7:0] bank, input logic [7:0] data,
                             input logic exp_err, input logic exp_frame, input logic use_model,
                             input logic [15:0] exp_data);
      logic [15:0] expd;
      applyStimulus(bank, data);
      expd = use_model ? modelFrame() : exp_data;
      checkOutput({name, "_err_pulse"}, 32'(BANK_ERR), 32'(exp_err));
      @(negedge CLK);
      checkOutput({name, "_err_clear"}, 32'(BANK_ERR), 32'd0);
      checkOutput({name, "_busy_start"}, 32'(BUSY), 32'(exp_frame));
      if (exp_frame) checkFrame(name, expd);
      else           checkNoFrame(name, 20);
   endtask

   initial begin
      vec_t        vecs [6];
      logic        found;
      logic [15:0] exp_a, exp_b;
      logic [7:0]  rb, rd;

      model_bank[0] = '0;
      model_bank[1] = '0;

      vecs[0] = '{bank: 8'd0,   data: 8'hA5, exp_err: 1'b0, exp_frame: 1'b1, exp_data: 16'h00A5};
      vecs[1] = '{bank: 8'd2,   data: 8'hFF, exp_err: 1'b1, exp_frame: 1'b0, exp_data: 16'h0000};
      vecs[2] = '{bank: 8'd1,   data: 8'h3C, exp_err: 1'b0, exp_frame: 1'b1, exp_data: 16'h3CA5};
      vecs[3] = '{bank: 8'd0,   data: 8'h0F, exp_err: 1'b0, exp_frame: 1'b1, exp_data: 16'h3C0F};
      vecs[4] = '{bank: 8'hC8,  data: 8'h55, exp_err: 1'b1, exp_frame: 1'b0, exp_data: 16'h0000};
      vecs[5] = '{bank: 8'd1,   data: 8'h81, exp_err: 1'b0, exp_frame: 1'b1, exp_data: 16'h810F};

      repeat (3) @(negedge CLK);
      checkOutput("reset_busy", 32'(BUSY), 32'd0);
      checkOutput("reset_sclk", 32'(SCLK), 32'd0);
      checkOutput("reset_latch", 32'(LATCH), 32'd0);
      checkOutput("reset_sdo", 32'(SDO), 32'd0);
      checkOutput("reset_bank_err", 32'(BANK_ERR), 32'd0);
      RST = 1'b0;
      @(negedge CLK);
      checkOutput("post_reset_busy", 32'(BUSY), 32'd0);

`ifdef BANK_SHIFT_OUT_REFRESH_EN
      begin
         frame_t f0, f1, f2;
         logic   ok0, ok1, ok2;
         waitFrame(f0, ok0);
         waitFrame(f1, ok1);
         waitFrame(f2, ok2);
         checkOutput("refresh_frames_seen", 32'({ok0, ok1, ok2}), 32'b111);
         checkOutput("refresh_f0_data", 32'(f0.data), 32'd0);
         checkOutput("refresh_f1_data", 32'(f1.data), 32'd0);
         checkOutput("refresh_f0_nbits", f0.nbits, FRAME_LEN);
         checkOutput("refresh_f0_busy_len", f0.busy_len, BUSY_LEN);
         checkOutput("refresh_period_1", f1.start_cyc - f0.start_cyc, 100);
         checkOutput("refresh_period_2", f2.start_cyc - f1.start_cyc, 100);
      end
`else
      checkNoFrame("idle_after_reset", 30);

      for (int i = 0; i < 6; i++) begin
         checkWrite($sformatf("vec%0d", i), vecs[i].bank, vecs[i].data,
                    vecs[i].exp_err, vecs[i].exp_frame, 1'b0, vecs[i].exp_data);
      end

      // Writes during bit 5 of a running frame: current frame keeps its snapshot, one more frame follows.
      applyStimulus(8'd0, 8'h55);
      exp_a = modelFrame();
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge CLK);
         if (mon_active && mon_nbits >= 5) found = 1'b1;
      end
      checkOutput("mid_reach_bit5", 32'(found), 32'd1);
      applyStimulus(8'd1, 8'h3C);
      applyStimulus(8'd0, 8'h66);
      exp_b = modelFrame();
      checkFrame("mid_first", exp_a);
      checkFrame("mid_second", exp_b);
      checkOutput("mid_second_hi_bits", 32'(exp_b[15:8]), 32'h3C);
      checkNoFrame("mid_only_one_more", 60);

      // Second write lands in the LOAD cycle: old data shifts first, new data gets its own frame.
      applyStimulus(8'd0, 8'hC3);
      exp_a = modelFrame();
      applyStimulus(8'd1, 8'hE7);
      exp_b = modelFrame();
      checkFrame("load_first", exp_a);
      checkFrame("load_second", exp_b);
      checkNoFrame("load_done", 60);

      // Asynchronous reset while SCLK is high aborts the frame with no latch.
      applyStimulus(8'd0, 8'h0F);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge CLK);
         if (SCLK) found = 1'b1;
      end
      checkOutput("rst_mid_reach_hi", 32'(found), 32'd1);
      checkOutput("rst_mid_sdo_before", 32'(SDO), 32'd1);
      #1 RST = 1'b1;
      #1;
      checkOutput("rst_mid_sclk", 32'(SCLK), 32'd0);
      checkOutput("rst_mid_sdo", 32'(SDO), 32'd0);
      checkOutput("rst_mid_latch", 32'(LATCH), 32'd0);
      checkOutput("rst_mid_busy", 32'(BUSY), 32'd0);
      model_bank[0] = '0;
      model_bank[1] = '0;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      checkNoFrame("rst_mid_aborted", 10);
      checkWrite("rst_mid_after", 8'd1, 8'h5A, 1'b0, 1'b1, 1'b0, 16'h5A00);

      for (int i = 0; i < 20; i++) begin
         rb = 8'($urandom_range(0, 3));
         rd = 8'($urandom);
         checkWrite($sformatf("rand%0d", i), rb, rd, rb >= 8'd2, rb < 8'd2, 1'b1, 16'h0000);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
